// File: rtl/uut_pipeadd01.sv
`default_nettype none
// ============================================================================
// Module      : uut_pipeadd01
// Description : Pipelined ripple-carry adder with valid/ready handshake.
//               The WIDTH-bit addition is split into STAGES chunks. Each
//               stage adds one chunk and registers its carry. All stages
//               advance together or stall together.
// Revision    : 1.0 - initial release
// ============================================================================
module uut_pipeadd01 #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("uut_pipeadd01: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
        end
    endgenerate

    // Per-stage registered state. Stage k holds the valid bit, the carry out
    // of chunk k, the sum bits produced so far (chunks 0..k) and the operands
    // still needed by later chunks. Operands travel with the slot, so chunk k
    // of an operation is delayed k register levels and meets its own carry.
    logic             vld_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];

    // Next-state values produced by each stage's combinational adder.
    logic             vld_d [STAGES];
    logic             cy_d  [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];

    // Whole pipeline moves when the output slot is empty or being taken.
    // Depends only on registered state and out_ready, never on in_valid.
    logic advance;
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int               LSB        = k * CHUNK;
        localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}}) << LSB;

        logic             src_vld;
        logic             src_cy;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;

        if (k == 0) begin : g_first
            assign src_vld = in_valid;
            assign src_cy  = cin;
            assign src_a   = a;
            assign src_b   = b;
            assign src_sum = '0;
        end else begin : g_next
            assign src_vld = vld_q[k-1];
            assign src_cy  = cy_q[k-1];
            assign src_a   = a_q[k-1];
            assign src_b   = b_q[k-1];
            assign src_sum = sum_q[k-1];
        end

        // Ripple chain of full-adder cells across this stage's chunk.
        logic [CHUNK:0]   carry;
        logic [CHUNK-1:0] part_sum;
        assign carry[0] = src_cy;

        for (genvar j = 0; j < CHUNK; j++) begin : g_fa
            logic ax;
            logic bx;
            assign ax           = src_a[LSB+j];
            assign bx           = src_b[LSB+j];
            assign part_sum[j]  = ax ^ bx ^ carry[j];
            assign carry[j+1]   = (ax & bx) | (carry[j] & (ax ^ bx));
        end

        assign vld_d[k] = src_vld;
        assign cy_d[k]  = carry[CHUNK];
        assign a_d[k]   = src_a;
        assign b_d[k]   = src_b;
        assign sum_d[k] = (src_sum & ~CHUNK_MASK) | (WIDTH'(part_sum) << LSB);
    end

    // Stage registers: async clear, global shift on advance, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                cy_q[k]  <= cy_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign y         = sum_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];

endmodule
`default_nettype wire

// File: doc/uut_pipeadd01.md
UUT_PIPEADD01 -- requirements
Module: uut_pipeadd01

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, >= 1.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline stages; 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0, else elaboration error.
REQ-003 SHALL derive CHUNK = WIDTH/STAGES: bits added per stage.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports as below.
REQ-005 clk  input  1  clock; all state rising-edge triggered.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  a, b, cin carry a valid operation.
REQ-008 in_ready  output  1  block accepts an operation this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 cin  input  1  carry-in.
REQ-012 out_valid  output  1  y and cout hold a valid result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 y  output  WIDTH  sum, (a+b+cin) mod 2^WIDTH.
REQ-015 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-016 SHALL accept an operation on any rising edge where in_valid && in_ready.
REQ-017 SHALL set advance = !out_valid || out_ready (combinational), drive in_ready = advance, and have no combinational path from in_valid to in_ready.
REQ-018 SHALL shift all stage registers, including bubbles, on every edge where advance = 1, and hold all stage registers unchanged where advance = 0 (global stall).
REQ-019 SHALL have stage k (0..STAGES-1) add bits [k*CHUNK +: CHUNK] of a and b plus the carry registered by stage k-1 (stage 0 uses cin), as a generate loop of ripple full-adder cells.
REQ-020 SHALL delay the operand chunks used by stage k by k register levels so that every chunk of a given operation stays aligned with its own carry.
REQ-021 SHALL carry a per-stage valid bit; a stage holding an invalid slot SHALL NOT assert out_valid when it reaches the output.
REQ-022 SHALL present a result exactly STAGES cycles after acceptance when not stalled; throughput SHALL be one operation per cycle.
REQ-023 SHALL hold y, cout and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL deliver results in acceptance order, with none lost or duplicated under any stall pattern.
REQ-025 SHALL, for STAGES=1, behave as a single registered WIDTH-bit adder; for STAGES=WIDTH, register a carry after every bit.
REQ-026 SHALL produce cout = 1 exactly when a+b+cin >= 2^WIDTH; it SHALL not wrap or saturate.
REQ-027 SHALL, on in_valid=1 with advance=0, leave the input unaccepted; the source holds its values until in_ready.

Reset
REQ-028 SHALL, on rst_n=0, immediately clear all valid bits, stage data, carries, y, cout, and out_valid to 0, independent of clk.
REQ-029 SHALL, during reset and in the first cycle after it, drive in_ready=1 (out_valid=0).
REQ-030 SHALL discard all in-flight operations on a mid-operation reset; no stale result SHALL appear after reset release.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-031 Reset then in_valid=0, out_ready=1 for 10 cycles -> out_valid=0, y=0x00, cout=0 throughout.
REQ-032 a=0xFF, b=0x01, cin=0, one cycle, out_ready=1 -> after exactly 2 cycles, out_valid=1 for 1 cycle, y=0x00, cout=1.
REQ-033 Cross-chunk carry: a=0x0F, b=0x00, cin=1 -> y=0x10, cout=0; then a=0x80, b=0x80, cin=1 -> y=0x01, cout=1, on consecutive cycles.
REQ-034 Stream 0x01+0x01, 0x02+0x02, 0x03+0x03, 0x04+0x04 back-to-back, out_ready=0 for 3 cycles once the first result appears -> in_ready=0 while stalled, y=0x02 held, then 0x02, 0x04, 0x06, 0x08 in order, none dropped.
REQ-035 Accept two operations, assert rst_n=0 mid-flight for 1 cycle -> out_valid=0 immediately and no result from either operation ever appears.
REQ-036 Random 10k operations with random in_valid/out_ready, for (WIDTH,STAGES) = (8,1), (8,2), (8,8), (32,4) -> every result matches the scoreboard {cout,y} = a+b+cin, in order.
